// File: rtl/axi4_sram_slave_if.sv
// AXI4 channel interfaces used by the SRAM slave endpoint.
// One interface per channel kind; AW and AR share AXI4_A_IF.
interface AXI4_A_IF #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                  avalid;
  logic                  aready;
  logic [ID_WIDTH-1:0]   aid;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [7:0]            alen;
  logic [2:0]            asize;
  logic [1:0]            aburst;
  logic [3:0]            acache;
  logic [2:0]            aprot;
  logic [3:0]            aqos;
  logic [3:0]            aregion;

  modport master (
    output avalid, aid, aaddr, alen, asize, aburst,
    output acache, aprot, aqos, aregion,
    input  aready
  );
  modport slave (
    input  avalid, aid, aaddr, alen, asize, aburst,
    input  acache, aprot, aqos, aregion,
    output aready
  );
endinterface

interface AXI4_W_IF #(
  parameter int DATA_WIDTH = 64
);
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  modport master (output wvalid, wdata, wstrb, wlast, input wready);
  modport slave  (input wvalid, wdata, wstrb, wlast, output wready);
endinterface

interface AXI4_B_IF #(
  parameter int ID_WIDTH = 4
);
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;

  modport master (input bvalid, bid, bresp, output bready);
  modport slave  (output bvalid, bid, bresp, input bready);
endinterface

interface AXI4_R_IF #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
);
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (input rvalid, rid, rdata, rresp, rlast, output rready);
  modport slave  (output rvalid, rid, rdata, rresp, rlast, input rready);
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a flop-array memory.
// Independent write (AW/W/B) and read (AR/R) burst engines.
module axi4_sram_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024
) (
  input logic     aclk,
  input logic     areset_n,
  AXI4_A_IF.slave aw_if,
  AXI4_W_IF.slave w_if,
  AXI4_B_IF.slave b_if,
  AXI4_A_IF.slave ar_if,
  AXI4_R_IF.slave r_if
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int SB = $clog2(SW);
  localparam int IW = ADDR_WIDTH - SB;
  localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IW-1:0] DEPTH = IW'(MEM_DEPTH);
  localparam logic [2:0] MAXSZ = 3'(SB);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] adv(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] mask;
    bytes = ADDR_WIDTH'(1) << size;
    mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes)
          - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   adv = a;
      2'b10:   adv = (a & ~mask) | ((a + bytes) & mask);
      default: adv = a + bytes;
    endcase
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:SB] < DEPTH;
  endfunction

  function automatic logic [MW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return a[SB +: MW];
  endfunction

  logic unused_fields;
  assign unused_fields = ^{aw_if.acache, aw_if.aprot, aw_if.aqos,
                           aw_if.aregion, ar_if.acache, ar_if.aprot,
                           ar_if.aqos, ar_if.aregion};

  // ---------------- write engine ----------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  aw_rdy, w_rdy, b_vld;
  logic                  aw_rdy_d, w_rdy_d, b_vld_d;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic                  aw_hs, w_hs, b_hs, w_ok, beat_err;

  assign aw_hs    = aw_if.avalid & aw_rdy;
  assign w_hs     = w_if.wvalid & w_rdy;
  assign b_hs     = b_vld & b_if.bready;
  assign w_ok     = in_range(w_addr);
  assign beat_err = ~w_ok | (w_if.wlast != (w_beat == w_len));

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state <= W_IDLE;
    else           w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_if.wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Handshake outputs are flopped decodes of the next state.
  always_comb begin
    aw_rdy_d = (w_next == W_IDLE);
    w_rdy_d  = (w_next == W_DATA);
    b_vld_d  = (w_next == W_RESP);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_rdy  <= 1'b0;
      w_rdy   <= 1'b0;
      b_vld   <= 1'b0;
      b_id    <= '0;
      b_resp  <= OKAY;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      aw_rdy <= aw_rdy_d;
      w_rdy  <= w_rdy_d;
      b_vld  <= b_vld_d;
      if (aw_hs) begin
        w_id    <= aw_if.aid;
        w_addr  <= aw_if.aaddr;
        w_len   <= aw_if.alen;
        w_size  <= aw_if.asize;
        w_burst <= aw_if.aburst;
        w_beat  <= '0;
        w_err   <= (aw_if.asize > MAXSZ) | (aw_if.aburst == 2'b11);
      end
      if (w_hs) begin
        w_addr <= adv(w_addr, w_len, w_size, w_burst);
        w_beat <= w_beat + 8'd1;
        w_err  <= w_err | beat_err;
        if (w_if.wlast) begin
          b_id   <= w_id;
          b_resp <= (w_err | beat_err) ? SLVERR : OKAY;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs && w_ok) begin
      for (int i = 0; i < SW; i++) begin
        if (w_if.wstrb[i]) mem[idx(w_addr)][8*i +: 8] <= w_if.wdata[8*i +: 8];
      end
    end
  end

  assign aw_if.aready = aw_rdy;
  assign w_if.wready  = w_rdy;
  assign b_if.bvalid  = b_vld;
  assign b_if.bid     = b_id;
  assign b_if.bresp   = b_resp;

  // ---------------- read engine ----------------
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, ld_addr;
  logic [7:0]            r_len, r_beat, ld_len, ld_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err, ld_err, ld_ok, r_load;
  logic                  ar_rdy, r_vld, ar_rdy_d, r_vld_d;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  ar_hs, r_hs;

  assign ar_hs = ar_if.avalid & ar_rdy;
  assign r_hs  = r_vld & r_if.rready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= R_IDLE;
    else           r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_rdy_d = (r_next == R_IDLE);
    r_vld_d  = (r_next == R_DATA);
  end

  // Beat to present next: first beat on AR, following beat on R.
  always_comb begin
    ld_addr = ar_hs ? ar_if.aaddr : adv(r_addr, r_len, r_size, r_burst);
    ld_beat = ar_hs ? 8'd0 : r_beat + 8'd1;
    ld_len  = ar_hs ? ar_if.alen : r_len;
    ld_err  = ar_hs ? ((ar_if.asize > MAXSZ) | (ar_if.aburst == 2'b11))
                    : r_err;
    ld_ok   = in_range(ld_addr);
    r_load  = ar_hs | (r_hs & ~r_last);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ar_rdy  <= 1'b0;
      r_vld   <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_resp  <= OKAY;
      r_last  <= 1'b0;
    end else begin
      ar_rdy <= ar_rdy_d;
      r_vld  <= r_vld_d;
      if (ar_hs) begin
        r_id    <= ar_if.aid;
        r_len   <= ar_if.alen;
        r_size  <= ar_if.asize;
        r_burst <= ar_if.aburst;
        r_err   <= ld_err;
      end
      if (r_load) begin
        r_addr <= ld_addr;
        r_beat <= ld_beat;
        r_data <= ld_ok ? mem[idx(ld_addr)] : '0;
        r_resp <= (ld_err | ~ld_ok) ? SLVERR : OKAY;
        r_last <= (ld_beat == ld_len);
      end
    end
  end

  assign ar_if.aready = ar_rdy;
  assign r_if.rvalid  = r_vld;
  assign r_if.rid     = r_id;
  assign r_if.rdata   = r_data;
  assign r_if.rresp   = r_resp;
  assign r_if.rlast   = r_last;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave.
// Scenario tasks run in sequence and compare inline.
module tb_axi4_sram_slave;
  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [5:0]  bg;
  logic [70:0] rg;

  always #5 aclk = ~aclk;

  AXI4_A_IF aw();
  AXI4_A_IF ar();
  AXI4_W_IF w();
  AXI4_B_IF b();
  AXI4_R_IF r();

  axi4_sram_slave dut (
    .aclk(aclk), .areset_n(areset_n),
    .aw_if(aw), .w_if(w), .b_if(b), .ar_if(ar), .r_if(r)
  );

  function automatic logic [70:0] rexp(input logic [3:0] id,
    input logic [1:0] resp, input logic last, input logic [63:0] d);
    return {id, resp, last, d};
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a,
    input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    aw.aid = id; aw.aaddr = a; aw.alen = len;
    aw.asize = sz; aw.aburst = bu; aw.avalid = 1'b1;
    while (aw.aready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL aw_timeout awready=%b required=1", aw.aready);
    end
    @(posedge aclk); #1;
    aw.avalid = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a,
    input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    ar.aid = id; ar.aaddr = a; ar.alen = len;
    ar.asize = sz; ar.aburst = bu; ar.avalid = 1'b1;
    while (ar.aready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL ar_timeout arready=%b required=1", ar.aready);
    end
    @(posedge aclk); #1;
    ar.avalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s,
    input logic last);
    int n = 0;
    w.wdata = d; w.wstrb = s; w.wlast = last; w.wvalid = 1'b1;
    while (w.wready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL w_timeout wready=%b required=1", w.wready);
    end
    @(posedge aclk); #1;
    w.wvalid = 1'b0;
  endtask

  task automatic b_get(output logic [5:0] got);
    int n = 0;
    b.bready = 1'b1;
    while (b.bvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    got = {b.bid, b.bresp};
    if (n >= 50) begin
      checks++; failures++; got = 'x;
      $display("FAIL b_timeout bvalid=%b required=1", b.bvalid);
    end
    @(posedge aclk); #1;
    b.bready = 1'b0;
  endtask

  task automatic r_get(output logic [70:0] got);
    int n = 0;
    r.rready = 1'b1;
    while (r.rvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    got = {r.rid, r.rresp, r.rlast, r.rdata};
    if (n >= 50) begin
      checks++; failures++; got = 'x;
      $display("FAIL r_timeout rvalid=%b required=1", r.rvalid);
    end
    @(posedge aclk); #1;
    r.rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({aw.aready, w.wready, b.bvalid, ar.aready, r.rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_hs got=%b required=00000",
        {aw.aready, w.wready, b.bvalid, ar.aready, r.rvalid});
    end
    checks++;
    if ({b.bid, b.bresp, r.rid, r.rresp, r.rlast, r.rdata} !== 77'b0) begin
      failures++;
      $display("FAIL reset_payload got=%h required=0",
        {b.bid, b.bresp, r.rid, r.rresp, r.rlast, r.rdata});
    end
    areset_n = 1'b1;
    #1;
    checks++;
    if ({aw.aready, ar.aready} !== 2'b00) begin
      failures++;
      $display("FAIL ready_at_release got=%b required=00",
        {aw.aready, ar.aready});
    end
    @(posedge aclk); #1;
    checks++;
    if ({aw.aready, ar.aready, w.wready} !== 3'b110) begin
      failures++;
      $display("FAIL ready_after_release got=%b required=110",
        {aw.aready, ar.aready, w.wready});
    end
  endtask

  task automatic test_single();
    aw_send(4'd3, 32'h10, 8'd0, 3'd3, 2'b01);
    w_send(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
    b_get(bg);
    checks++;
    if (bg !== {4'd3, 2'b00}) begin
      failures++;
      $display("FAIL single_b got=%h required=%h", bg, {4'd3, 2'b00});
    end
    ar_send(4'd3, 32'h10, 8'd0, 3'd3, 2'b01);
    r_get(rg);
    checks++;
    if (rg !== rexp(4'd3, 2'b00, 1'b1, 64'hDEADBEEF_CAFEF00D)) begin
      failures++;
      $display("FAIL single_r got=%h required=%h", rg,
        rexp(4'd3, 2'b00, 1'b1, 64'hDEADBEEF_CAFEF00D));
    end
  endtask

  task automatic test_incr();
    logic [63:0] ex [4];
    ex[0] = 64'd1; ex[1] = 64'hFFFF_FFFF_0000_0002;
    ex[2] = 64'd3; ex[3] = 64'd4;
    aw_send(4'd1, 32'h108, 8'd0, 3'd3, 2'b01);
    w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_get(bg);
    aw_send(4'd5, 32'h100, 8'd3, 3'd3, 2'b01);
    for (int i = 1; i <= 4; i++)
      w_send(64'(i), (i == 2) ? 8'h0F : 8'hFF, i == 4);
    b_get(bg);
    checks++;
    if (bg !== {4'd5, 2'b00}) begin
      failures++;
      $display("FAIL incr_b got=%h required=%h", bg, {4'd5, 2'b00});
    end
    ar_send(4'd6, 32'h100, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_get(rg);
      checks++;
      if (rg !== rexp(4'd6, 2'b00, i == 3, ex[i])) begin
        failures++;
        $display("FAIL incr_r%0d got=%h required=%h", i, rg,
          rexp(4'd6, 2'b00, i == 3, ex[i]));
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] ex [4];
    ex[0] = 64'h22; ex[1] = 64'h33; ex[2] = 64'h44; ex[3] = 64'h11;
    aw_send(4'd2, 32'h18, 8'd3, 3'd3, 2'b10);
    for (int i = 1; i <= 4; i++) w_send(64'(i * 17), 8'hFF, i == 4);
    b_get(bg);
    checks++;
    if (bg !== {4'd2, 2'b00}) begin
      failures++;
      $display("FAIL wrap_b got=%h required=%h", bg, {4'd2, 2'b00});
    end
    ar_send(4'd2, 32'h00, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_get(rg);
      checks++;
      if (rg !== rexp(4'd2, 2'b00, i == 3, ex[i])) begin
        failures++;
        $display("FAIL wrap_incr_r%0d got=%h required=%h", i, rg,
          rexp(4'd2, 2'b00, i == 3, ex[i]));
      end
    end
    ar_send(4'd7, 32'h18, 8'd3, 3'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      r_get(rg);
      checks++;
      if (rg !== rexp(4'd7, 2'b00, i == 3, 64'((i + 1) * 17))) begin
        failures++;
        $display("FAIL wrap_wrap_r%0d got=%h required=%h", i, rg,
          rexp(4'd7, 2'b00, i == 3, 64'((i + 1) * 17)));
      end
    end
  endtask

  task automatic test_errors();
    aw_send(4'd4, 32'h2000, 8'd1, 3'd3, 2'b01);
    w_send(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
    w_send(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1);
    b_get(bg);
    checks++;
    if (bg !== {4'd4, 2'b10}) begin
      failures++;
      $display("FAIL oor_b got=%h required=%h", bg, {4'd4, 2'b10});
    end
    ar_send(4'd4, 32'h2000, 8'd1, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) begin
      r_get(rg);
      checks++;
      if (rg !== rexp(4'd4, 2'b10, i == 1, 64'd0)) begin
        failures++;
        $display("FAIL oor_r%0d got=%h required=%h", i, rg,
          rexp(4'd4, 2'b10, i == 1, 64'd0));
      end
    end
    ar_send(4'd1, 32'h0, 8'd1, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) begin
      r_get(rg);
      checks++;
      if (rg !== rexp(4'd1, 2'b00, i == 1, 64'((i + 2) * 17))) begin
        failures++;
        $display("FAIL oor_nowrite_r%0d got=%h required=%h", i, rg,
          rexp(4'd1, 2'b00, i == 1, 64'((i + 2) * 17)));
      end
    end
    aw_send(4'd9, 32'h40, 8'd0, 3'd4, 2'b01);
    w_send(64'h1, 8'hFF, 1'b1);
    b_get(bg);
    checks++;
    if (bg !== {4'd9, 2'b10}) begin
      failures++;
      $display("FAIL size_b got=%h required=%h", bg, {4'd9, 2'b10});
    end
    ar_send(4'd9, 32'h40, 8'd0, 3'd4, 2'b01);
    r_get(rg);
    checks++;
    if (rg[70:64] !== {4'd9, 2'b10, 1'b1}) begin
      failures++;
      $display("FAIL size_r got=%h required=%h", rg[70:64],
        {4'd9, 2'b10, 1'b1});
    end
    aw_send(4'd10, 32'h80, 8'd1, 3'd3, 2'b01);
    w_send(64'h2, 8'hFF, 1'b1);
    b_get(bg);
    checks++;
    if (bg !== {4'd10, 2'b10}) begin
      failures++;
      $display("FAIL early_wlast_b got=%h required=%h", bg, {4'd10, 2'b10});
    end
    aw_send(4'd11, 32'h200, 8'd0, 3'd3, 2'b11);
    w_send(64'h5A5A, 8'hFF, 1'b1);
    b_get(bg);
    checks++;
    if (bg !== {4'd11, 2'b10}) begin
      failures++;
      $display("FAIL burst3_b got=%h required=%h", bg, {4'd11, 2'b10});
    end
    ar_send(4'd11, 32'h200, 8'd0, 3'd3, 2'b01);
    r_get(rg);
    checks++;
    if (rg !== rexp(4'd11, 2'b00, 1'b1, 64'h5A5A)) begin
      failures++;
      $display("FAIL burst3_r got=%h required=%h", rg,
        rexp(4'd11, 2'b00, 1'b1, 64'h5A5A));
    end
  endtask

  task automatic test_stall();
    aw_send(4'd12, 32'h300, 8'd0, 3'd3, 2'b01);
    w_send(64'h1234, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({b.bvalid, b.bid, b.bresp, aw.aready} !== {1'b1, 4'd12, 2'b00, 1'b0}) begin
        failures++;
        $display("FAIL b_stall%0d got=%h required=%h", i,
          {b.bvalid, b.bid, b.bresp, aw.aready}, {1'b1, 4'd12, 2'b00, 1'b0});
      end
      @(posedge aclk); #1;
    end
    b_get(bg);
    checks++;
    if (bg !== {4'd12, 2'b00}) begin
      failures++;
      $display("FAIL stall_b got=%h required=%h", bg, {4'd12, 2'b00});
    end
    ar_send(4'd13, 32'h300, 8'd0, 3'd3, 2'b01);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({r.rvalid, r.rid, r.rresp, r.rlast, r.rdata, ar.aready} !==
          {1'b1, 4'd13, 2'b00, 1'b1, 64'h1234, 1'b0}) begin
        failures++;
        $display("FAIL r_stall%0d got=%h required=%h", i,
          {r.rvalid, r.rid, r.rresp, r.rlast, r.rdata, ar.aready},
          {1'b1, 4'd13, 2'b00, 1'b1, 64'h1234, 1'b0});
      end
      @(posedge aclk); #1;
    end
    r_get(rg);
    checks++;
    if (rg !== rexp(4'd13, 2'b00, 1'b1, 64'h1234)) begin
      failures++;
      $display("FAIL stall_r got=%h required=%h", rg,
        rexp(4'd13, 2'b00, 1'b1, 64'h1234));
    end
  endtask

  task automatic test_reset_mid();
    aw_send(4'd14, 32'h400, 8'd3, 3'd3, 2'b01);
    w_send(64'h1, 8'hFF, 1'b0);
    w.wdata = 64'h2; w.wstrb = 8'hFF; w.wlast = 1'b0; w.wvalid = 1'b1;
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if ({aw.aready, w.wready, b.bvalid, ar.aready, r.rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_hs got=%b required=00000",
        {aw.aready, w.wready, b.bvalid, ar.aready, r.rvalid});
    end
    w.wvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      checks++;
      if (b.bvalid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_nob%0d got=%b required=0", i, b.bvalid);
      end
    end
    aw_send(4'd15, 32'h400, 8'd0, 3'd3, 2'b01);
    w_send(64'hF00D, 8'hFF, 1'b1);
    b_get(bg);
    checks++;
    if (bg !== {4'd15, 2'b00}) begin
      failures++;
      $display("FAIL midrst_b got=%h required=%h", bg, {4'd15, 2'b00});
    end
    ar_send(4'd15, 32'h400, 8'd0, 3'd3, 2'b01);
    r_get(rg);
    checks++;
    if (rg !== rexp(4'd15, 2'b00, 1'b1, 64'hF00D)) begin
      failures++;
      $display("FAIL midrst_r got=%h required=%h", rg,
        rexp(4'd15, 2'b00, 1'b1, 64'hF00D));
    end
  endtask

  initial begin
    aw.avalid = 0; aw.aid = 0; aw.aaddr = 0; aw.alen = 0; aw.asize = 0;
    aw.aburst = 0; aw.acache = 0; aw.aprot = 0; aw.aqos = 0; aw.aregion = 0;
    ar.avalid = 0; ar.aid = 0; ar.aaddr = 0; ar.alen = 0; ar.asize = 0;
    ar.aburst = 0; ar.acache = 0; ar.aprot = 0; ar.aqos = 0; ar.aregion = 0;
    w.wvalid = 0; w.wdata = 0; w.wstrb = 0; w.wlast = 0;
    b.bready = 0;
    r.rready = 0;
    test_reset();
    test_single();
    test_incr();
    test_wrap();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
